// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO for any DEPTH >= 2.
// Read mode is either a registered read (FWFT=0) or first-word-fall-through (FWFT=1).
// It provides almost-full/almost-empty thresholds, an occupancy count,
// one-cycle reject pulses and a synchronous flush.
// All outputs come directly from registers.
module sync_fifo_flex #(
    parameter int    WIDTH     = 16,
    parameter int    DEPTH     = 16,
    parameter int    FWFT      = 0,
    parameter int    AF_THRESH = DEPTH - 2,
    parameter int    AE_THRESH = 2,
    parameter string TARGET    = "Xilinx"
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_flush,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_wr_en,
    input  logic                         i_rd_en,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_valid,
    output logic                         o_full,
    output logic                         o_empty,
    output logic                         o_almost_full,
    output logic                         o_almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_wr_err,
    output logic                         o_rd_err
);

    localparam int               PW       = $clog2(DEPTH);
    localparam int               CW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]    PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0]    DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]    AF_C     = CW'(AF_THRESH);
    localparam logic [CW-1:0]    AE_C     = CW'(AE_THRESH);
    localparam logic             AF_RST   = (AF_THRESH <= 0);

    // Reject illegal configurations at elaboration time.
    if (DEPTH < 2) begin : g_err_depth
        $error("sync_fifo_flex: DEPTH must be >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_err_af
        $error("sync_fifo_flex: AF_THRESH must lie in 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_err_ae
        $error("sync_fifo_flex: AE_THRESH must lie in 0..DEPTH-1");
    end
    if ((TARGET != "Xilinx") && (TARGET != "Generic")) begin : g_err_target
        $error("sync_fifo_flex: TARGET must be \"Xilinx\" or \"Generic\"");
    end

    // Storage is deliberately never reset. A location is only ever read after it has been written.
    (* ram_style = "distributed" *)
    logic [WIDTH-1:0] r_mem [0:DEPTH-1];

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_full;
    logic             r_empty;
    logic             r_afull;
    logic             r_aempty;
    logic             r_wr_err;
    logic             r_rd_err;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [PW-1:0]    w_wr_ptr_next;
    logic [PW-1:0]    w_rd_ptr_next;
    logic [CW-1:0]    w_count_next;
    logic [WIDTH-1:0] w_data_next;
    logic             w_valid_next;

    // Pointer advance with an explicit wrap, so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // A request is accepted based on the flags before the edge. Flush wins over any request.
    assign w_wr_acc = i_wr_en && !r_full  && !i_flush;
    assign w_rd_acc = i_rd_en && !r_empty && !i_flush;

    // Next pointers: advance only on an accepted operation.
    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        if (w_wr_acc) begin
            w_wr_ptr_next = ptr_inc(r_wr_ptr);
        end else begin
            w_wr_ptr_next = r_wr_ptr;
        end
        if (w_rd_acc) begin
            w_rd_ptr_next = ptr_inc(r_rd_ptr);
        end else begin
            w_rd_ptr_next = r_rd_ptr;
        end
    end

    // Next occupancy: a simultaneous read and write leave the count unchanged.
    always_comb begin
        w_count_next = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_next = r_count + CW'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_next = r_count - CW'(1);
        end else begin
            w_count_next = r_count;
        end
    end

    // Next output word and valid for the selected read mode.
    always_comb begin
        w_data_next  = r_data;
        w_valid_next = r_valid;
        if (FWFT != 0) begin
            // o_data tracks the head word. After a pop, the next entry is already in storage
            // unless the FIFO held one word and that word is being replaced in the same cycle.
            w_valid_next = (w_count_next != CW'(0));
            if (w_rd_acc) begin
                if (r_count > CW'(1)) begin
                    w_data_next = r_mem[w_rd_ptr_next];
                end else if (w_wr_acc) begin
                    w_data_next = i_data;
                end else begin
                    w_data_next = r_data;
                end
            end else if (w_wr_acc && r_empty) begin
                w_data_next = i_data;
            end else begin
                w_data_next = r_data;
            end
        end else begin
            // Registered read: the popped word appears in the cycle after the accepted read.
            w_valid_next = w_rd_acc;
            if (w_rd_acc) begin
                w_data_next = r_mem[r_rd_ptr];
            end else begin
                w_data_next = r_data;
            end
        end
    end

    // Storage write port.
    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Control state, registered flags and output word.
    // Async reset and synchronous flush return everything to the same values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= AF_RST;
            r_aempty <= 1'b1;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= AF_RST;
            r_aempty <= 1'b1;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_data   <= w_data_next;
            r_valid  <= w_valid_next;
            r_full   <= (w_count_next == DEPTH_C);
            r_empty  <= (w_count_next == CW'(0));
            r_afull  <= (w_count_next >= AF_C);
            r_aempty <= (w_count_next <= AE_C);
            r_wr_err <= i_wr_en && r_full;
            r_rd_err <= i_rd_en && r_empty;
        end
    end

    assign o_data         = r_data;
    assign o_valid        = r_valid;
    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_almost_full  = r_afull;
    assign o_almost_empty = r_aempty;
    assign o_count        = r_count;
    assign o_wr_err       = r_wr_err;
    assign o_rd_err       = r_rd_err;

endmodule
